// File: rtl/zap_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zap_mem_pkg
// Description : Shared types and constants for the memory align stage:
//               load access size encoding, stage state encoding and the
//               bit positions inside the 5-bit exception vector
//               {abt,irq,fiq,swi,und}.
// Revision    : 1.0 - initial release
// ============================================================================
package zap_mem_pkg;

  // Load access size as delivered by the post-ALU stage.
  typedef enum logic [2:0] {
    ZAP_MEM_WORD  = 3'd0,
    ZAP_MEM_UBYTE = 3'd1,
    ZAP_MEM_SBYTE = 3'd2,
    ZAP_MEM_UHALF = 3'd3,
    ZAP_MEM_SHALF = 3'd4
  } zap_mem_size_t;

  // RUN: capture each unstalled cycle. SLEEP: parked after a data abort
  // until writeback flushes the pipe.
  typedef enum logic [0:0] {
    ZAP_MEM_RUN   = 1'b0,
    ZAP_MEM_SLEEP = 1'b1
  } zap_mem_state_t;

  // Exception vector layout {abt,irq,fiq,swi,und}.
  localparam int unsigned c_exc_wdt     = 5;
  localparam int unsigned c_exc_und_bit = 0;
  localparam int unsigned c_exc_swi_bit = 1;
  localparam int unsigned c_exc_fiq_bit = 2;
  localparam int unsigned c_exc_irq_bit = 3;
  localparam int unsigned c_exc_abt_bit = 4;

endpackage
`default_nettype wire

// File: rtl/zap_memory_align_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : zap_memory_align_stage_if
// Description : Data-cache response bus seen by the memory align stage.
//   data_stall     : dcache stall; the stage holds all state while high
//   data_mem_fault : data abort for the current access (valid when !stall)
//   data_rd_dat    : dcache read word (valid when !stall)
//   Modports: master = dcache side (drives), slave = align stage (samples).
// Revision    : 1.0 - initial release
// ============================================================================
interface zap_memory_align_stage_if;

  logic        data_stall;
  logic        data_mem_fault;
  logic [31:0] data_rd_dat;

  modport master (
    output data_stall,
    output data_mem_fault,
    output data_rd_dat
  );

  modport slave (
    input data_stall,
    input data_mem_fault,
    input data_rd_dat
  );

endinterface
`default_nettype wire

// File: rtl/zap_load_aligner.sv
`default_nettype none
// ============================================================================
// Module      : zap_load_aligner
// Description : Combinational load data aligner. Selects the byte/halfword
//               lane addressed by i_addr and zero/sign extends it. For word
//               loads the behaviour depends on macro
//               ZAP_MEM_ROTATE_UNALIGNED_EN: defined -> rotate right by
//               8*i_addr (ARMv4 unaligned word load), undefined -> the word
//               is returned as read (force-aligned).
//   i_data : 32-bit dcache read word
//   i_addr : access address [1:0]
//   i_size : access size
//   o_data : aligned, extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module zap_load_aligner
  import zap_mem_pkg::*;
(
  input  logic [31:0]   i_data,
  input  logic [1:0]    i_addr,
  input  zap_mem_size_t i_size,
  output logic [31:0]   o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  always_comb begin
    w_byte = i_data[7:0];
    case (i_addr)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
  end

  // Halfword lane is picked by addr[1] alone; addr[0] is ignored.
  assign w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

`ifdef ZAP_MEM_ROTATE_UNALIGNED_EN
  always_comb begin
    w_word = i_data;
    case (i_addr)
      2'd0:    w_word = i_data;
      2'd1:    w_word = {i_data[7:0],  i_data[31:8]};
      2'd2:    w_word = {i_data[15:0], i_data[31:16]};
      default: w_word = {i_data[23:0], i_data[31:24]};
    endcase
  end
`else
  assign w_word = i_data;
`endif

  always_comb begin
    o_data = w_word;
    case (i_size)
      ZAP_MEM_UBYTE: o_data = {24'd0, w_byte};
      ZAP_MEM_SBYTE: o_data = {{24{w_byte[7]}}, w_byte};
      ZAP_MEM_UHALF: o_data = {16'd0, w_half};
      ZAP_MEM_SHALF: o_data = {{16{w_half[15]}}, w_half};
      default:       o_data = w_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/zap_memory_align_stage.sv
`default_nettype none
// ============================================================================
// Module      : zap_memory_align_stage
// Description : Memory stage after the post-ALU register stage. Captures the
//               dcache read word, aligns/extends it per access size and
//               registers it with the instruction for writeback. A data
//               fault becomes a registered abort, after which the stage
//               sleeps until writeback flushes the pipe.
//               Build option: ZAP_MEM_ROTATE_UNALIGNED_EN (rotate unaligned
//               word loads; see zap_load_aligner).
// Ports:
//   i_clk, i_reset_n (async active-low), i_clear_from_writeback (flush)
//   dbus            : dcache stall / fault / read data (slave modport)
//   i_*_ff          : instruction fields from the post-ALU stage
//   o_*_ff          : registered instruction fields, aligned load data and
//                     data abort flag towards writeback
// Revision    : 1.0 - initial release
// ============================================================================
module zap_memory_align_stage
  import zap_mem_pkg::*;
#(
  parameter int unsigned PHY_REGS = 32'd46,
  parameter int unsigned FLAG_WDT = 32'd32,
  parameter int unsigned IDX      = $clog2(PHY_REGS)
)(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear_from_writeback,
  zap_memory_align_stage_if.slave dbus,

  input  logic                  i_dav_ff,
  input  logic [c_exc_wdt-1:0]  i_exc_ff,
  input  logic [31:0]           i_alu_result_ff,
  input  logic [FLAG_WDT-1:0]   i_flags_ff,
  input  logic [IDX-1:0]        i_destination_index_ff,
  input  logic [31:0]           i_pc_plus_8_ff,
  input  logic                  i_mem_load_ff,
  input  logic [IDX-1:0]        i_mem_srcdest_index_ff,
  input  logic [31:0]           i_mem_address_ff,
  input  logic [2:0]            i_mem_size_ff,

  output logic                  o_dav_ff,
  output logic [c_exc_wdt-1:0]  o_exc_ff,
  output logic [31:0]           o_alu_result_ff,
  output logic [FLAG_WDT-1:0]   o_flags_ff,
  output logic [IDX-1:0]        o_destination_index_ff,
  output logic [31:0]           o_pc_plus_8_ff,
  output logic                  o_mem_load_ff,
  output logic [IDX-1:0]        o_mem_srcdest_index_ff,
  output logic [31:0]           o_mem_load_data_ff,
  output logic                  o_data_abt_ff
);

  zap_mem_state_t r_state;
  zap_mem_state_t w_state_nxt;

  logic [31:0]          w_aligned;
  logic                 w_fault;
  logic                 w_ctl_en;
  logic                 w_cap_en;
  logic                 w_dav_nxt;
  logic [c_exc_wdt-1:0] w_exc_nxt;
  logic                 w_load_nxt;
  logic                 w_abt_nxt;
  logic                 w_unused_addr;

  // Only the lane bits of the address matter to this stage.
  assign w_unused_addr = ^i_mem_address_ff[31:2];

  zap_load_aligner u_aligner (
    .i_data (dbus.data_rd_dat),
    .i_addr (i_mem_address_ff[1:0]),
    .i_size (zap_mem_size_t'(i_mem_size_ff)),
    .o_data (w_aligned)
  );

  // An instruction already carrying an exception never issued an access,
  // so a fault is only meaningful for a clean, valid instruction.
  assign w_fault = i_dav_ff && (i_exc_ff == '0) && dbus.data_mem_fault;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ZAP_MEM_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: clear wins over stall, stall freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear_from_writeback) begin
      w_state_nxt = ZAP_MEM_RUN;
    end else if (!dbus.data_stall) begin
      case (r_state)
        ZAP_MEM_RUN:   w_state_nxt = w_fault ? ZAP_MEM_SLEEP : ZAP_MEM_RUN;
        ZAP_MEM_SLEEP: w_state_nxt = ZAP_MEM_SLEEP;
        default:       w_state_nxt = ZAP_MEM_RUN;
      endcase
    end
  end

  // Output logic: decides which output registers update and with what.
  // w_ctl_en covers the valid/exception/load/abort controls, w_cap_en the
  // data fields; data fields simply hold when not captured.
  always_comb begin
    w_ctl_en   = 1'b0;
    w_cap_en   = 1'b0;
    w_dav_nxt  = 1'b0;
    w_exc_nxt  = '0;
    w_load_nxt = 1'b0;
    w_abt_nxt  = 1'b0;
    if (i_clear_from_writeback) begin
      w_ctl_en = 1'b1;
    end else if (!dbus.data_stall) begin
      case (r_state)
        ZAP_MEM_RUN: begin
          w_ctl_en   = 1'b1;
          w_cap_en   = 1'b1;
          w_dav_nxt  = i_dav_ff;
          w_exc_nxt  = i_exc_ff;
          w_load_nxt = i_dav_ff && i_mem_load_ff && !w_fault;
          w_abt_nxt  = w_fault;
        end
        default: begin
          w_ctl_en = 1'b1;
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dav_ff               <= 1'b0;
      o_exc_ff               <= '0;
      o_alu_result_ff        <= '0;
      o_flags_ff             <= '0;
      o_destination_index_ff <= '0;
      o_pc_plus_8_ff         <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_srcdest_index_ff <= '0;
      o_mem_load_data_ff     <= '0;
      o_data_abt_ff          <= 1'b0;
    end else begin
      if (w_ctl_en) begin
        o_dav_ff      <= w_dav_nxt;
        o_exc_ff      <= w_exc_nxt;
        o_mem_load_ff <= w_load_nxt;
        o_data_abt_ff <= w_abt_nxt;
      end
      if (w_cap_en) begin
        o_alu_result_ff        <= i_alu_result_ff;
        o_flags_ff             <= i_flags_ff;
        o_destination_index_ff <= i_destination_index_ff;
        o_pc_plus_8_ff         <= i_pc_plus_8_ff;
        o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
        o_mem_load_data_ff     <= w_aligned;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zap_memory_align_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_zap_memory_align_stage
// Description : Self-checking bench for zap_memory_align_stage. Directed
//               alignment cases, stall/fault/sleep/clear sequences, async
//               reset, and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_memory_align_stage;

  localparam int unsigned PHY_REGS = 46;
  localparam int unsigned FLAG_WDT = 32;
  localparam int unsigned IDX      = $clog2(PHY_REGS);

  logic                i_clk = 1'b0;
  logic                i_reset_n;
  logic                i_clear_from_writeback;
  logic                i_dav_ff;
  logic [4:0]          i_exc_ff;
  logic [31:0]         i_alu_result_ff;
  logic [FLAG_WDT-1:0] i_flags_ff;
  logic [IDX-1:0]      i_destination_index_ff;
  logic [31:0]         i_pc_plus_8_ff;
  logic                i_mem_load_ff;
  logic [IDX-1:0]      i_mem_srcdest_index_ff;
  logic [31:0]         i_mem_address_ff;
  logic [2:0]          i_mem_size_ff;

  logic                o_dav_ff;
  logic [4:0]          o_exc_ff;
  logic [31:0]         o_alu_result_ff;
  logic [FLAG_WDT-1:0] o_flags_ff;
  logic [IDX-1:0]      o_destination_index_ff;
  logic [31:0]         o_pc_plus_8_ff;
  logic                o_mem_load_ff;
  logic [IDX-1:0]      o_mem_srcdest_index_ff;
  logic [31:0]         o_mem_load_data_ff;
  logic                o_data_abt_ff;

  zap_memory_align_stage_if dbus ();

  zap_memory_align_stage #(
    .PHY_REGS (PHY_REGS),
    .FLAG_WDT (FLAG_WDT)
  ) dut (
    .i_clk                  (i_clk),
    .i_reset_n              (i_reset_n),
    .i_clear_from_writeback (i_clear_from_writeback),
    .dbus                   (dbus.slave),
    .i_dav_ff               (i_dav_ff),
    .i_exc_ff               (i_exc_ff),
    .i_alu_result_ff        (i_alu_result_ff),
    .i_flags_ff             (i_flags_ff),
    .i_destination_index_ff (i_destination_index_ff),
    .i_pc_plus_8_ff         (i_pc_plus_8_ff),
    .i_mem_load_ff          (i_mem_load_ff),
    .i_mem_srcdest_index_ff (i_mem_srcdest_index_ff),
    .i_mem_address_ff       (i_mem_address_ff),
    .i_mem_size_ff          (i_mem_size_ff),
    .o_dav_ff               (o_dav_ff),
    .o_exc_ff               (o_exc_ff),
    .o_alu_result_ff        (o_alu_result_ff),
    .o_flags_ff             (o_flags_ff),
    .o_destination_index_ff (o_destination_index_ff),
    .o_pc_plus_8_ff         (o_pc_plus_8_ff),
    .o_mem_load_ff          (o_mem_load_ff),
    .o_mem_srcdest_index_ff (o_mem_srcdest_index_ff),
    .o_mem_load_data_ff     (o_mem_load_data_ff),
    .o_data_abt_ff          (o_data_abt_ff)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs. exp_known clears after a flush, where data fields are
  // don't-care; control fields are always defined.
  logic        exp_dav, exp_load, exp_abt, exp_sleep, exp_known;
  logic [4:0]  exp_exc;
  logic [31:0] exp_alu, exp_flags, exp_pc, exp_ldata;
  logic [31:0] exp_dst, exp_src;

  // Lane selection and extension computed arithmetically from the rules.
  function automatic logic [31:0] ref_align(input logic [31:0] d,
                                            input logic [1:0] a,
                                            input logic [2:0] sz);
    int unsigned b;
    int unsigned h;
    logic [63:0] t;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    t = {d, d} >> (8 * a);
    case (sz)
      3'd1:    return b;
      3'd2:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    return h;
      3'd4:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
`ifdef ZAP_MEM_ROTATE_UNALIGNED_EN
      default: return t[31:0];
`else
      default: return (t[31:0] == 32'd0) ? d : d;
`endif
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dav"},  {31'd0, o_dav_ff},      {31'd0, exp_dav});
    chk({tag, ".exc"},  {27'd0, o_exc_ff},      {27'd0, exp_exc});
    chk({tag, ".load"}, {31'd0, o_mem_load_ff}, {31'd0, exp_load});
    chk({tag, ".abt"},  {31'd0, o_data_abt_ff}, {31'd0, exp_abt});
    if (exp_known) begin
      chk({tag, ".alu"},   o_alu_result_ff, exp_alu);
      chk({tag, ".flags"}, o_flags_ff,      exp_flags);
      chk({tag, ".dst"},   {26'd0, o_destination_index_ff}, exp_dst);
      chk({tag, ".pc"},    o_pc_plus_8_ff,  exp_pc);
      chk({tag, ".src"},   {26'd0, o_mem_srcdest_index_ff}, exp_src);
      chk({tag, ".ldata"}, o_mem_load_data_ff, exp_ldata);
    end
  endtask

  task automatic model_reset();
    exp_dav = 0; exp_load = 0; exp_abt = 0; exp_sleep = 0; exp_known = 1;
    exp_exc = 0; exp_alu = 0; exp_flags = 0; exp_pc = 0; exp_ldata = 0;
    exp_dst = 0; exp_src = 0;
  endtask

  // Applies the stage rules to the inputs present before the next edge.
  task automatic model_edge();
    logic f;
    if (i_clear_from_writeback) begin
      exp_dav = 0; exp_exc = 0; exp_load = 0; exp_abt = 0;
      exp_sleep = 0; exp_known = 0;
    end else if (dbus.data_stall) begin
      // everything holds
    end else if (exp_sleep) begin
      exp_dav = 0; exp_exc = 0; exp_load = 0; exp_abt = 0;
    end else begin
      f = i_dav_ff && (i_exc_ff == 5'd0) && dbus.data_mem_fault;
      exp_dav   = i_dav_ff;
      exp_exc   = i_exc_ff;
      exp_load  = i_dav_ff && i_mem_load_ff && !f;
      exp_abt   = f;
      exp_alu   = i_alu_result_ff;
      exp_flags = i_flags_ff;
      exp_dst   = {26'd0, i_destination_index_ff};
      exp_pc    = i_pc_plus_8_ff;
      exp_src   = {26'd0, i_mem_srcdest_index_ff};
      exp_ldata = ref_align(dbus.data_rd_dat, i_mem_address_ff[1:0], i_mem_size_ff);
      exp_known = 1;
      if (f) exp_sleep = 1;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_fields();
    i_dav_ff               = ($urandom_range(0, 4) != 0);
    i_exc_ff               = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
    i_alu_result_ff        = $urandom;
    i_flags_ff             = $urandom;
    i_destination_index_ff = IDX'($urandom_range(0, PHY_REGS - 1));
    i_pc_plus_8_ff         = $urandom;
    i_mem_load_ff          = $urandom_range(0, 1) == 1;
    i_mem_srcdest_index_ff = IDX'($urandom_range(0, PHY_REGS - 1));
    i_mem_address_ff       = $urandom;
    i_mem_size_ff          = 3'($urandom_range(0, 4));
    dbus.data_rd_dat       = $urandom;
  endtask

  task automatic load_op(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] rd);
    rand_fields();
    i_dav_ff = 1; i_exc_ff = 0; i_mem_load_ff = 1;
    i_mem_address_ff = addr; i_mem_size_ff = sz; dbus.data_rd_dat = rd;
    dbus.data_stall = 0; dbus.data_mem_fault = 0; i_clear_from_writeback = 0;
  endtask

  logic [31:0] exp_word101;

  initial begin
    i_reset_n = 0; i_clear_from_writeback = 0;
    dbus.data_stall = 0; dbus.data_mem_fault = 0;
    rand_fields();
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_all("reset");
    i_reset_n = 1;

    // Directed alignment cases
    load_op(32'h100, 3'd0, 32'hDEAD_BEEF);
    step("word0");
    chk("word0.const", o_mem_load_data_ff, 32'hDEAD_BEEF);
    chk("word0.loaden", {31'd0, o_mem_load_ff}, 32'd1);

    load_op(32'h103, 3'd2, 32'h80FF_0000);
    step("sbyte3");
    chk("sbyte3.const", o_mem_load_data_ff, 32'hFFFF_FF80);

    load_op(32'h102, 3'd3, 32'h80FF_0000);
    step("uhalf2");
    chk("uhalf2.const", o_mem_load_data_ff, 32'h0000_80FF);

    load_op(32'h101, 3'd0, 32'h1122_3344);
    step("word1");
`ifdef ZAP_MEM_ROTATE_UNALIGNED_EN
    exp_word101 = 32'h4411_2233;
`else
    exp_word101 = 32'h1122_3344;
`endif
    chk("word1.const", o_mem_load_data_ff, exp_word101);

    // Stall three cycles with fresh inputs: nothing moves
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      dbus.data_stall = 1;
      dbus.data_mem_fault = $urandom_range(0, 1) == 1;
      step("stall");
    end
    chk("stall.held", o_mem_load_data_ff, exp_word101);

    // Fault on a clean load -> abort, then sleep
    load_op(32'h200, 3'd0, 32'h1234_5678);
    dbus.data_mem_fault = 1;
    step("fault");
    chk("fault.abt", {31'd0, o_data_abt_ff}, 32'd1);
    chk("fault.dav", {31'd0, o_dav_ff}, 32'd1);
    chk("fault.load", {31'd0, o_mem_load_ff}, 32'd0);

    load_op(32'h204, 3'd0, 32'hCAFE_F00D);
    step("sleep");
    chk("sleep.dav", {31'd0, o_dav_ff}, 32'd0);

    // Clear together with stall leaves SLEEP
    load_op(32'h208, 3'd1, 32'hAABB_CCDD);
    dbus.data_stall = 1; i_clear_from_writeback = 1;
    step("clr_stall");
    chk("clr_stall.dav", {31'd0, o_dav_ff}, 32'd0);

    load_op(32'h209, 3'd1, 32'hAABB_CCDD);
    step("after_clr");
    chk("after_clr.dav", {31'd0, o_dav_ff}, 32'd1);
    chk("after_clr.ldata", o_mem_load_data_ff, 32'h0000_00CC);

    // Exception present: fault ignored
    load_op(32'h300, 3'd4, 32'h8001_7FFF);
    i_exc_ff = 5'b00010; dbus.data_mem_fault = 1;
    step("exc_nofault");
    chk("exc_nofault.abt", {31'd0, o_data_abt_ff}, 32'd0);
    chk("exc_nofault.ldata", o_mem_load_data_ff, 32'h0000_7FFF);

    // Randomized run
    for (int i = 0; i < 200; i++) begin
      rand_fields();
      dbus.data_stall        = ($urandom_range(0, 3) == 0);
      dbus.data_mem_fault    = ($urandom_range(0, 7) == 0);
      i_clear_from_writeback = ($urandom_range(0, 11) == 0);
      step("rand");
    end

    // Async reset mid-operation
    load_op(32'h400, 3'd0, 32'h5555_AAAA);
    step("pre_rst");
    #2;
    i_reset_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge i_clk);
    #1;
    i_reset_n = 1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
